vga_card_grid: RTL and testbench
================================

# vga_card_grid

Parametrised card-grid renderer and pair-matching controller for the VGA memory game, placed between `hvsync_generator` and the board RGB pins. It draws a ROWS×COLS grid of square cards with configurable size, gap and origin. It moves a wrap-around selection cursor from debounced button pulses and runs the flip/hold/compare state machine that turns cards up, matches pairs and reports score. Card faces come in as a flat bus from the upstream shuffler; face bitmaps come from an external asynchronous ROM.

## Interface
Parameters:
- `ROWS`, 4, grid rows (1–8)
- `COLS`, 4, grid columns (1–8); ROWS*COLS must be even
- `CELL`, 64, card edge in pixels (power of two, 8–64)
- `GAP`, 10, pixels between cards
- `ORIGIN_X`, 20, left edge of card (0,0)
- `ORIGIN_Y`, 20, top edge of card (0,0)
- `BORDER`, 5, cursor border thickness; must be ≤ GAP/2 and ≤ ORIGIN_X, ORIGIN_Y
- `HOLD_FRAMES`, 60, frames two up cards stay visible before resolving (≥1)
- `FACE_W`, 3, face-id width

Ports:
- `clk` in 1: pixel clock (`DIV_CLK[1]`)
- `reset` in 1: synchronous, active-high
- `CounterX`, `CounterY` in 10 each: raster position from `hvsync_generator`
- `inDisplayArea` in 1: raster is in the 640×480 area
- `UP`, `DOWN`, `LEFT`, `RIGHT`, `SEL` in 1 each: single-cycle debounced pulses (SCEN)
- `card_faces` in ROWS*COLS*FACE_W: face id of card k at bits [k*FACE_W +: FACE_W], k = row*COLS+col
- `rom_face` out FACE_W: face id whose bitmap is addressed
- `rom_y`, `rom_x` out log2(CELL) each: pixel within the card
- `rom_pixel` in 1: bitmap bit, combinational from the rom_* outputs
- `vga_r`, `vga_g`, `vga_b` out 1 each: registered colour
- `cursor_row`, `cursor_col` out 3 each: cursor position
- `match_count` out 6: pairs matched
- `mismatch` out 1: one-cycle pulse when a compared pair differs
- `done` out 1: all pairs matched
- `state` out 3: FSM state, for LEDs

## Operation
- Card state array holds 2 bits per card: DOWN=0, UP=1, MATCHED=2. Reset sets every card to DOWN.
- Cursor:
  - One move per cycle, priority DOWN, UP, RIGHT, LEFT.
  - A move is ignored when its opposite direction pulses in the same cycle.
  - Row wraps modulo ROWS and column wraps modulo COLS, including for non-power-of-two sizes: ROWS-1 + DOWN gives 0, and 0 + UP gives ROWS-1.
  - The cursor moves in every FSM state.
- FSM states:
  - IDLE=0:
    - SEL on a DOWN card sets it UP, stores its index as `first`, and goes to ONE=1.
    - SEL on an UP or MATCHED card is ignored.
  - ONE:
    - SEL on a DOWN card sets it UP, stores its index as `second`, clears the hold counter, and goes to HOLD=2.
    - Other SEL presses are ignored.
  - HOLD:
    - The hold counter increments on each frame tick.
    - The FSM goes to RESOLVE=3 when the counter reaches HOLD_FRAMES.
    - SEL is ignored.
  - RESOLVE, one cycle:
    - If the faces are equal, both cards become MATCHED and `match_count` increments. The FSM goes to DONE=4 if `match_count` then equals ROWS*COLS/2, otherwise to IDLE.
    - If the faces differ, both cards become DOWN, `mismatch` pulses, and the FSM goes to IDLE.
  - DONE: `done`=1 and the FSM holds until reset.
- Frame tick: one-cycle pulse when CounterX==0 and CounterY==480.
- Render stage 1 (registered): hit-tests the raster against every cell, and registers cell index, local x/y, cursor-border hit and inDisplayArea. `rom_face`, `rom_x` and `rom_y` are driven from these registers.
- Render stage 2 (registered): colour priority is:
  - !inDisplayArea → 000
  - cursor border → 001
  - DOWN card → 010 solid
  - UP card → rom_pixel ? 111 : 000
  - MATCHED card → rom_pixel ? 110 : 000
  - gap or background → 000
- Cursor border: a BORDER-wide frame surrounding the selected cell, outside the card and inside the gap.

## Timing
- Reset values: `vga_r/g/b`=0, cursor (0,0), `match_count`=0, `mismatch`=0, `done`=0, `state`=IDLE, rom_* outputs 0, all cards DOWN.
- RGB latency: colour for raster (X,Y) appears 2 clk after CounterX/CounterY present (X,Y). The display shifts by 2 pixels, which is accepted.
- A SEL pulse changes card state and `state` on the next edge; the change shows in video no earlier than the next raster pass.
- Hold time is HOLD_FRAMES frame ticks after entering HOLD, plus at most one frame. RESOLVE lasts exactly 1 clk.
- Simultaneous SEL and move in one cycle: the select applies to the pre-move cursor position.
- Reset asserted mid-hold or mid-frame: everything returns to reset values on that edge; stage registers clear, so the next 2 pixels are black.

## Configuration
- `VGA_GRID_CURSOR_BLINK_EN` defined: a 5-bit frame counter toggles cursor visibility every 16 frames. The border is drawn only while the counter's bit 4 is 0, and the counter resets to 0.
- Not defined: the cursor border is always drawn and the counter is not built.

## Test plan
- Reset then 5 DOWN pulses with ROWS=4 → cursor_row=1. Then LEFT from col 0 → cursor_col=3. Then UP and DOWN in the same cycle → no change.
- Faces {0,0,1,1,…}: SEL at card 0, RIGHT, SEL at card 1 → state 1 then 2, HOLD_FRAMES=2 ticks later RESOLVE → both MATCHED, match_count=1, state=IDLE.
- Faces differ at cards 0 and 2: SEL, SEL → after hold, mismatch=1 for exactly 1 clk and both cards DOWN. SEL on card 0 while in HOLD → ignored.
- Match every pair of a 2×2 grid → match_count=2, done=1, state=4. Further SEL → no change until reset.
- Raster at the pixel (ORIGIN_X+3, ORIGIN_Y+7) of a face-down card → rgb=010 two clk later. At (ORIGIN_X-1, ORIGIN_Y) with cursor at (0,0) → 001. With inDisplayArea=0 → 000.
- Reset mid-HOLD with two cards UP → all cards DOWN, state=IDLE, rgb=000 on the next 2 clk.

Source files
------------

// File: rtl/vga_card_grid_if.sv
// Raster, button, face, ROM and status bundle of the VGA card-grid renderer.
// master: raster/button/shuffler/ROM side.  slave: vga_card_grid.
interface vga_card_grid_if #(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned CELL   = 64,
    parameter int unsigned FACE_W = 3
);
    localparam int unsigned NCARDS = ROWS * COLS;
    localparam int unsigned LW     = $clog2(CELL);

    logic [9:0]               CounterX;
    logic [9:0]               CounterY;
    logic                     inDisplayArea;
    logic                     UP;
    logic                     DOWN;
    logic                     LEFT;
    logic                     RIGHT;
    logic                     SEL;
    logic [NCARDS*FACE_W-1:0] card_faces;
    logic [FACE_W-1:0]        rom_face;
    logic [LW-1:0]            rom_y;
    logic [LW-1:0]            rom_x;
    logic                     rom_pixel;
    logic                     vga_r;
    logic                     vga_g;
    logic                     vga_b;
    logic [2:0]               cursor_row;
    logic [2:0]               cursor_col;
    logic [5:0]               match_count;
    logic                     mismatch;
    logic                     done;
    logic [2:0]               state;

    modport master (
        output CounterX, CounterY, inDisplayArea,
        output UP, DOWN, LEFT, RIGHT, SEL,
        output card_faces, rom_pixel,
        input  rom_face, rom_y, rom_x,
        input  vga_r, vga_g, vga_b,
        input  cursor_row, cursor_col, match_count, mismatch, done, state
    );

    modport slave (
        input  CounterX, CounterY, inDisplayArea,
        input  UP, DOWN, LEFT, RIGHT, SEL,
        input  card_faces, rom_pixel,
        output rom_face, rom_y, rom_x,
        output vga_r, vga_g, vga_b,
        output cursor_row, cursor_col, match_count, mismatch, done, state
    );
endinterface

// File: rtl/vga_card_grid.sv
// Card-grid renderer and pair-matching controller for the VGA memory game.
// Draws a ROWS x COLS grid of cards, moves a wrapping cursor, flips/compares
// pairs and keeps score. Two-stage registered pixel pipeline (RGB latency 2).
// Optional: define VGA_GRID_CURSOR_BLINK_EN to blink the cursor every 16 frames.
module vga_card_grid #(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 4,
    parameter int unsigned CELL        = 64,
    parameter int unsigned GAP         = 10,
    parameter int unsigned ORIGIN_X    = 20,
    parameter int unsigned ORIGIN_Y    = 20,
    parameter int unsigned BORDER      = 5,
    parameter int unsigned HOLD_FRAMES = 60,
    parameter int unsigned FACE_W      = 3
) (
    input logic            clk,
    input logic            reset,
    vga_card_grid_if.slave bus
);
    localparam int unsigned NCARDS = ROWS * COLS;
    localparam int unsigned NPAIRS = NCARDS / 2;
    localparam int unsigned IW     = (NCARDS > 1) ? $clog2(NCARDS) : 1;
    localparam int unsigned LW     = $clog2(CELL);
    localparam int unsigned PITCH  = CELL + GAP;
    localparam int unsigned HW     = $clog2(HOLD_FRAMES + 1);

    localparam logic [1:0] CS_DOWN    = 2'd0;
    localparam logic [1:0] CS_UP      = 2'd1;
    localparam logic [1:0] CS_MATCHED = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ONE     = 3'd1,
        S_HOLD    = 3'd2,
        S_RESOLVE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [2*NCARDS-1:0]   r_cards, w_cards_nxt;
    logic [IW-1:0]         r_first, w_first_nxt;
    logic [IW-1:0]         r_second, w_second_nxt;
    logic [HW-1:0]         r_hold, w_hold_nxt;
    logic [5:0]            r_mc, w_mc_nxt;
    logic                  r_mismatch, w_mismatch_nxt;
    logic                  r_done;
    logic [2:0]            r_cur_row, r_cur_col, w_row_nxt, w_col_nxt;

    logic                  w_frame_tick;
    logic                  w_mv_dn, w_mv_up, w_mv_rt, w_mv_lt;
    logic [IW-1:0]         w_cur_idx;
    logic [1:0]            w_cur_cs;
    logic [FACE_W-1:0]     w_face_a, w_face_b;
    logic [HW-1:0]         w_hold_inc;
    logic                  w_cursor_vis;

    assign w_frame_tick = (bus.CounterX == 10'd0) && (bus.CounterY == 10'd480);

    // A direction counts only when its opposite is not pulsing too
    assign w_mv_dn = bus.DOWN  & ~bus.UP;
    assign w_mv_up = bus.UP    & ~bus.DOWN;
    assign w_mv_rt = bus.RIGHT & ~bus.LEFT;
    assign w_mv_lt = bus.LEFT  & ~bus.RIGHT;

    assign w_cur_idx  = IW'(r_cur_row) * IW'(COLS) + IW'(r_cur_col);
    assign w_cur_cs   = r_cards[int'(w_cur_idx)*2 +: 2];
    assign w_face_a   = bus.card_faces[int'(r_first)*FACE_W +: FACE_W];
    assign w_face_b   = bus.card_faces[int'(r_second)*FACE_W +: FACE_W];
    assign w_hold_inc = r_hold + HW'(1);

    // Cursor next position: one wrapping move, priority DOWN, UP, RIGHT, LEFT
    always_comb begin
        w_row_nxt = r_cur_row;
        w_col_nxt = r_cur_col;
        if (w_mv_dn)
            w_row_nxt = (r_cur_row == 3'(ROWS - 1)) ? 3'd0 : r_cur_row + 3'd1;
        else if (w_mv_up)
            w_row_nxt = (r_cur_row == 3'd0) ? 3'(ROWS - 1) : r_cur_row - 3'd1;
        else if (w_mv_rt)
            w_col_nxt = (r_cur_col == 3'(COLS - 1)) ? 3'd0 : r_cur_col + 3'd1;
        else if (w_mv_lt)
            w_col_nxt = (r_cur_col == 3'd0) ? 3'(COLS - 1) : r_cur_col - 3'd1;
    end

    // Cursor register; select logic sees the pre-move position
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_row <= 3'd0;
            r_cur_col <= 3'd0;
        end else begin
            r_cur_row <= w_row_nxt;
            r_cur_col <= w_col_nxt;
        end
    end

    // Game FSM next state and datapath updates
    always_comb begin
        w_state_nxt    = r_state;
        w_cards_nxt    = r_cards;
        w_first_nxt    = r_first;
        w_second_nxt   = r_second;
        w_hold_nxt     = r_hold;
        w_mc_nxt       = r_mc;
        w_mismatch_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.SEL && (w_cur_cs == CS_DOWN)) begin
                    w_cards_nxt[int'(w_cur_idx)*2 +: 2] = CS_UP;
                    w_first_nxt = w_cur_idx;
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (bus.SEL && (w_cur_cs == CS_DOWN)) begin
                    w_cards_nxt[int'(w_cur_idx)*2 +: 2] = CS_UP;
                    w_second_nxt = w_cur_idx;
                    w_hold_nxt   = '0;
                    w_state_nxt  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_frame_tick) begin
                    w_hold_nxt = w_hold_inc;
                    if (w_hold_inc >= HW'(HOLD_FRAMES))
                        w_state_nxt = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                if (w_face_a == w_face_b) begin
                    w_cards_nxt[int'(r_first)*2 +: 2]  = CS_MATCHED;
                    w_cards_nxt[int'(r_second)*2 +: 2] = CS_MATCHED;
                    w_mc_nxt    = r_mc + 6'd1;
                    w_state_nxt = ((r_mc + 6'd1) == 6'(NPAIRS)) ? S_DONE : S_IDLE;
                end else begin
                    w_cards_nxt[int'(r_first)*2 +: 2]  = CS_DOWN;
                    w_cards_nxt[int'(r_second)*2 +: 2] = CS_DOWN;
                    w_mismatch_nxt = 1'b1;
                    w_state_nxt    = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Card array, pair indices, hold counter and score registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cards    <= '0;
            r_first    <= '0;
            r_second   <= '0;
            r_hold     <= '0;
            r_mc       <= 6'd0;
            r_mismatch <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cards    <= w_cards_nxt;
            r_first    <= w_first_nxt;
            r_second   <= w_second_nxt;
            r_hold     <= w_hold_nxt;
            r_mc       <= w_mc_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

`ifdef VGA_GRID_CURSOR_BLINK_EN
    logic [4:0] r_blink_cnt;

    // Frame counter whose MSB hides the cursor for 16 of every 32 frames
    always_ff @(posedge clk) begin
        if (reset)             r_blink_cnt <= 5'd0;
        else if (w_frame_tick) r_blink_cnt <= r_blink_cnt + 5'd1;
    end

    assign w_cursor_vis = ~r_blink_cnt[4];
`else
    assign w_cursor_vis = 1'b1;
`endif

    // Render stage 1 combinational hit test (rows and columns independently)
    logic             w_row_hit, w_col_hit;
    logic [2:0]       w_hit_row, w_hit_col;
    logic [LW-1:0]    w_lx, w_ly;
    logic [IW-1:0]    w_hit_idx;
    logic [10:0]      w_px, w_py, w_cx0, w_cy0;
    logic             w_border;

    always_comb begin
        w_row_hit = 1'b0;
        w_col_hit = 1'b0;
        w_hit_row = 3'd0;
        w_hit_col = 3'd0;
        w_lx      = '0;
        w_ly      = '0;
        for (int r = 0; r < ROWS; r++) begin
            if ((w_py >= 11'(ORIGIN_Y + r*PITCH)) && (w_py < 11'(ORIGIN_Y + r*PITCH + CELL))) begin
                w_row_hit = 1'b1;
                w_hit_row = 3'(r);
                w_ly      = LW'(w_py - 11'(ORIGIN_Y + r*PITCH));
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if ((w_px >= 11'(ORIGIN_X + c*PITCH)) && (w_px < 11'(ORIGIN_X + c*PITCH + CELL))) begin
                w_col_hit = 1'b1;
                w_hit_col = 3'(c);
                w_lx      = LW'(w_px - 11'(ORIGIN_X + c*PITCH));
            end
        end
    end

    assign w_px      = {1'b0, bus.CounterX};
    assign w_py      = {1'b0, bus.CounterY};
    assign w_hit_idx = IW'(w_hit_row) * IW'(COLS) + IW'(w_hit_col);
    assign w_cx0     = 11'(ORIGIN_X) + 11'(r_cur_col) * 11'(PITCH);
    assign w_cy0     = 11'(ORIGIN_Y) + 11'(r_cur_row) * 11'(PITCH);

    // Border ring: within BORDER of the selected card but outside the card itself
    assign w_border = (w_px + 11'(BORDER) >= w_cx0) && (w_px < w_cx0 + 11'(CELL + BORDER)) &&
                      (w_py + 11'(BORDER) >= w_cy0) && (w_py < w_cy0 + 11'(CELL + BORDER)) &&
                      !((w_px >= w_cx0) && (w_px < w_cx0 + 11'(CELL)) &&
                        (w_py >= w_cy0) && (w_py < w_cy0 + 11'(CELL)));

    logic              r_s1_de, r_s1_hit, r_s1_border;
    logic [IW-1:0]     r_s1_idx;
    logic [FACE_W-1:0] r_s1_face;
    logic [LW-1:0]     r_s1_lx, r_s1_ly;

    // Render stage 1 registers; they also address the face ROM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_de     <= 1'b0;
            r_s1_hit    <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_face   <= '0;
            r_s1_lx     <= '0;
            r_s1_ly     <= '0;
        end else begin
            r_s1_de     <= bus.inDisplayArea;
            r_s1_hit    <= w_row_hit & w_col_hit;
            r_s1_border <= w_border;
            r_s1_idx    <= w_hit_idx;
            r_s1_face   <= (w_row_hit & w_col_hit) ? bus.card_faces[int'(w_hit_idx)*FACE_W +: FACE_W] : '0;
            r_s1_lx     <= (w_row_hit & w_col_hit) ? w_lx : '0;
            r_s1_ly     <= (w_row_hit & w_col_hit) ? w_ly : '0;
        end
    end

    logic [1:0] w_s1_cs;
    logic [2:0] w_rgb, r_rgb;

    assign w_s1_cs = r_cards[int'(r_s1_idx)*2 +: 2];

    // Render stage 2 colour priority
    always_comb begin
        w_rgb = 3'b000;
        if (!r_s1_de) begin
            w_rgb = 3'b000;
        end else if (r_s1_border && w_cursor_vis) begin
            w_rgb = 3'b001;
        end else if (r_s1_hit) begin
            case (w_s1_cs)
                CS_DOWN:    w_rgb = 3'b010;
                CS_UP:      w_rgb = bus.rom_pixel ? 3'b111 : 3'b000;
                CS_MATCHED: w_rgb = bus.rom_pixel ? 3'b110 : 3'b000;
                default:    w_rgb = 3'b000;
            endcase
        end
    end

    // Render stage 2 colour register
    always_ff @(posedge clk) begin
        if (reset) r_rgb <= 3'b000;
        else       r_rgb <= w_rgb;
    end

    assign bus.rom_face    = r_s1_face;
    assign bus.rom_x       = r_s1_lx;
    assign bus.rom_y       = r_s1_ly;
    assign bus.vga_r       = r_rgb[2];
    assign bus.vga_g       = r_rgb[1];
    assign bus.vga_b       = r_rgb[0];
    assign bus.cursor_row  = r_cur_row;
    assign bus.cursor_col  = r_cur_col;
    assign bus.match_count = r_mc;
    assign bus.mismatch    = r_mismatch;
    assign bus.done        = r_done;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_vga_card_grid.sv
// Scoreboard bench for vga_card_grid: expectations are queued with a due
// cycle when stimulus is driven and compared when that cycle's edge lands.
module tb_vga_card_grid;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned CELL  = 64;
    localparam int unsigned GAP   = 10;
    localparam int unsigned OX    = 20;
    localparam int unsigned OY    = 20;
    localparam int unsigned BRD   = 5;
    localparam int unsigned HOLD  = 2;
    localparam int unsigned FW    = 3;
    localparam int unsigned PITCH = CELL + GAP;

    localparam int SG_RGB = 0, SG_ROW = 1, SG_COL = 2, SG_MC = 3, SG_MM = 4;
    localparam int SG_DONE = 5, SG_STATE = 6, SG_RFACE = 7, SG_RX = 8, SG_RY = 9;
    localparam int D_DN = 0, D_UP = 1, D_RT = 2, D_LT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_card_grid_if #(.ROWS(ROWS), .COLS(COLS), .CELL(CELL), .FACE_W(FW)) bus ();

    vga_card_grid #(
        .ROWS(ROWS), .COLS(COLS), .CELL(CELL), .GAP(GAP),
        .ORIGIN_X(OX), .ORIGIN_Y(OY), .BORDER(BRD),
        .HOLD_FRAMES(HOLD), .FACE_W(FW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Face ROM model: lit only where both local coordinates are odd
    assign bus.rom_pixel = bus.rom_x[0] & bus.rom_y[0];

    typedef struct {
        string tag;
        int    sig;
        int    val;
        int    due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_row = 0;
    int   m_col = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input integer act, input integer exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic integer get_sig(input int s);
        case (s)
            SG_RGB:   return integer'({bus.vga_r, bus.vga_g, bus.vga_b});
            SG_ROW:   return integer'(bus.cursor_row);
            SG_COL:   return integer'(bus.cursor_col);
            SG_MC:    return integer'(bus.match_count);
            SG_MM:    return integer'(bus.mismatch);
            SG_DONE:  return integer'(bus.done);
            SG_STATE: return integer'(bus.state);
            SG_RFACE: return integer'(bus.rom_face);
            SG_RX:    return integer'(bus.rom_x);
            default:  return integer'(bus.rom_y);
        endcase
    endfunction

    // Compare every expectation whose due edge has just happened
    always @(posedge clk) begin
        #1;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                check_val(sb_q[i].tag, get_sig(sb_q[i].sig), sb_q[i].val);
                sb_q.delete(i);
            end
        end
    end

    task automatic expect_at(input string tag, input int sig, input int val, input int lat);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        e.due = cyc + lat;
        sb_q.push_back(e);
    endtask

    task automatic drive_defaults();
        reset             = 1'b0;
        bus.UP            = 1'b0;
        bus.DOWN          = 1'b0;
        bus.LEFT          = 1'b0;
        bus.RIGHT         = 1'b0;
        bus.SEL           = 1'b0;
        bus.CounterX      = 10'd700;
        bus.CounterY      = 10'd500;
        bus.inDisplayArea = 1'b0;
    endtask

    task automatic cyc_idle();
        @(negedge clk);
        drive_defaults();
    endtask

    task automatic press(input logic up, input logic dn, input logic lt, input logic rt, input logic sel);
        @(negedge clk);
        drive_defaults();
        bus.UP    = up;
        bus.DOWN  = dn;
        bus.LEFT  = lt;
        bus.RIGHT = rt;
        bus.SEL   = sel;
    endtask

    task automatic sel_expect(input int st, input string tag);
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(tag, SG_STATE, st, 1);
    endtask

    task automatic move(input int dir);
        case (dir)
            D_DN: begin press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); m_row = (m_row + 1) % ROWS; end
            D_UP: begin press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); m_row = (m_row + ROWS - 1) % ROWS; end
            D_RT: begin press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); m_col = (m_col + 1) % COLS; end
            default: begin press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); m_col = (m_col + COLS - 1) % COLS; end
        endcase
        expect_at("cursor_row", SG_ROW, m_row, 1);
        expect_at("cursor_col", SG_COL, m_col, 1);
    endtask

    task automatic goto_cell(input int tr, input int tc);
        while (m_row != tr) move(D_DN);
        while (m_col != tc) move(D_RT);
    endtask

    task automatic pixel(input int x, input int y, input logic de, input int exp_rgb, input string tag);
        @(negedge clk);
        drive_defaults();
        bus.CounterX      = 10'(x);
        bus.CounterY      = 10'(y);
        bus.inDisplayArea = de;
        expect_at(tag, SG_RGB, exp_rgb, 2);
    endtask

    task automatic frame_tick();
        @(negedge clk);
        drive_defaults();
        bus.CounterX = 10'd0;
        bus.CounterY = 10'd480;
    endtask

    task automatic hold_and_resolve(input int st_after, input int mc_after, input int mm);
        frame_tick();
        expect_at("hold_after_tick1", SG_STATE, 2, 1);
        cyc_idle();
        frame_tick();
        expect_at("enter_resolve", SG_STATE, 3, 1);
        expect_at("mismatch_low_in_resolve", SG_MM, 0, 1);
        expect_at("state_after_resolve", SG_STATE, st_after, 2);
        expect_at("match_count", SG_MC, mc_after, 2);
        expect_at("mismatch_pulse", SG_MM, mm, 2);
        expect_at("done_flag", SG_DONE, (st_after == 4) ? 1 : 0, 2);
        expect_at("mismatch_one_cycle", SG_MM, 0, 3);
        repeat (3) cyc_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ROWS*COLS*FW-1:0] faces;
        for (int k = 0; k < int'(ROWS*COLS); k++) faces[k*FW +: FW] = FW'(k / 2);
        bus.card_faces = faces;
        drive_defaults();
        reset             = 1'b1;
        bus.CounterX      = 10'(OX + 3);
        bus.CounterY      = 10'(OY + 7);
        bus.inDisplayArea = 1'b1;
        @(negedge clk);
        @(negedge clk);
        expect_at("reset_rgb", SG_RGB, 0, 1);
        expect_at("reset_row", SG_ROW, 0, 1);
        expect_at("reset_col", SG_COL, 0, 1);
        expect_at("reset_mc", SG_MC, 0, 1);
        expect_at("reset_mismatch", SG_MM, 0, 1);
        expect_at("reset_done", SG_DONE, 0, 1);
        expect_at("reset_state", SG_STATE, 0, 1);
        expect_at("reset_rom_face", SG_RFACE, 0, 1);
        expect_at("reset_rom_x", SG_RX, 0, 1);
        expect_at("reset_rom_y", SG_RY, 0, 1);
        @(negedge clk);
        drive_defaults();

        // Cursor wrap and opposite-direction cancel
        repeat (5) move(D_DN);
        move(D_LT);
        press(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at("updown_row", SG_ROW, m_row, 1);
        expect_at("updown_col", SG_COL, m_col, 1);
        press(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_at("leftright_col", SG_COL, m_col, 1);
        move(D_UP);
        goto_cell(0, 0);
        move(D_UP);
        goto_cell(0, 0);

        // Rendering of face-down cards, border, gap and blanking
        pixel(OX + 3, OY + 7, 1'b1, 3'b010, "down_card_rgb");
        expect_at("rom_x_local", SG_RX, 3, 1);
        expect_at("rom_y_local", SG_RY, 7, 1);
        pixel(OX - 1, OY, 1'b1, 3'b001, "border_left");
        pixel(OX - 1, OY, 1'b0, 3'b000, "no_display_area");
        pixel(OX + CELL + BRD - 1, OY + 10, 1'b1, 3'b001, "border_right_edge");
        pixel(OX + CELL + BRD, OY + 10, 1'b1, 3'b000, "gap_past_border");
        pixel(OX + PITCH + 3, OY + PITCH + 7, 1'b1, 3'b010, "down_card_1_1");
        expect_at("rom_face_card5", SG_RFACE, 2, 1);

        // Mismatch: cards 0 and 2, SEL in HOLD ignored
        sel_expect(1, "sel_first");
        move(D_RT);
        move(D_RT);
        sel_expect(2, "sel_second");
        move(D_LT);
        move(D_LT);
        sel_expect(2, "sel_in_hold_ignored");
        pixel(OX + 3, OY + 7, 1'b1, 3'b111, "up_card0_lit");
        pixel(OX + 2, OY + 7, 1'b1, 3'b000, "up_card0_dark");
        pixel(OX + 2*PITCH + 3, OY + 7, 1'b1, 3'b111, "up_card2_lit");
        expect_at("rom_face_card2", SG_RFACE, 1, 1);
        hold_and_resolve(0, 0, 1);
        pixel(OX + 3, OY + 7, 1'b1, 3'b010, "card0_down_after_mismatch");
        pixel(OX + 2*PITCH + 3, OY + 7, 1'b1, 3'b010, "card2_down_after_mismatch");

        // First match: cards 0 and 1
        sel_expect(1, "match_sel_first");
        move(D_RT);
        sel_expect(2, "match_sel_second");
        hold_and_resolve(0, 1, 0);
        pixel(OX + 3, OY + 7, 1'b1, 3'b110, "matched_card0_lit");
        pixel(OX + PITCH + 3, OY + 7, 1'b1, 3'b110, "matched_card1_lit");
        pixel(OX + PITCH + 3, OY + 6, 1'b1, 3'b000, "matched_card1_dark");
        sel_expect(0, "sel_matched_ignored");

        // Remaining pairs up to completion
        for (int k = 1; k < int'(ROWS*COLS/2); k++) begin
            goto_cell((2*k) / COLS, (2*k) % COLS);
            sel_expect(1, "pair_sel_first");
            move(D_RT);
            sel_expect(2, "pair_sel_second");
            hold_and_resolve((k == int'(ROWS*COLS/2) - 1) ? 4 : 0, k + 1, 0);
        end
        sel_expect(4, "sel_in_done");
        expect_at("done_holds", SG_DONE, 1, 1);
        expect_at("mc_holds", SG_MC, 8, 1);
        move(D_DN);
        frame_tick();
        expect_at("done_after_tick", SG_STATE, 4, 1);

        // Reset mid-HOLD with two cards up
        @(negedge clk);
        drive_defaults();
        reset = 1'b1;
        m_row = 0;
        m_col = 0;
        expect_at("game_reset_state", SG_STATE, 0, 1);
        expect_at("game_reset_done", SG_DONE, 0, 1);
        sel_expect(1, "new_sel_first");
        move(D_RT);
        sel_expect(2, "new_sel_second");
        frame_tick();
        expect_at("new_hold", SG_STATE, 2, 1);
        @(negedge clk);
        drive_defaults();
        reset             = 1'b1;
        bus.CounterX      = 10'(OX + 3);
        bus.CounterY      = 10'(OY + 7);
        bus.inDisplayArea = 1'b1;
        expect_at("midhold_reset_state", SG_STATE, 0, 1);
        expect_at("midhold_reset_mc", SG_MC, 0, 1);
        expect_at("midhold_reset_col", SG_COL, 0, 1);
        expect_at("midhold_reset_rom_x", SG_RX, 0, 1);
        expect_at("midhold_reset_rgb1", SG_RGB, 0, 1);
        expect_at("midhold_reset_rgb2", SG_RGB, 0, 2);
        pixel(OX + 3, OY + 7, 1'b1, 3'b010, "card0_down_after_reset");
        pixel(OX + PITCH + 3, OY + 7, 1'b1, 3'b010, "card1_down_after_reset");
        sel_expect(1, "sel_after_reset");

        repeat (4) cyc_idle();
        check_val("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
